wts_multi_adsr_envelope: RTL and testbench



---
 rtl/wts_env_pkg.sv | 35 +++
 rtl/wts_adsr_env_channel.sv | 151 +++++++++++++++
 rtl/wts_multi_adsr_envelope.sv | 48 ++++
 tb/tb_wts_multi_adsr_envelope.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wts_env_pkg.sv
// Shared definitions for the wave table ADSR envelope: state codes, state width
// and the helper that maps an envelope phase to the rate register it uses.
package wts_env_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } envState_e;

  typedef enum logic [2:0] {
    RSEL_NONE,
    RSEL_AR,
    RSEL_DR,
    RSEL_SR,
    RSEL_RR
  } rateSel_e;

  function automatic rateSel_e rateSel(input envState_e st);
    rateSel_e sel;
    case (st)
      ENV_ATTACK:  sel = RSEL_AR;
      ENV_DECAY:   sel = RSEL_DR;
      ENV_SUSTAIN: sel = RSEL_SR;
      ENV_RELEASE: sel = RSEL_RR;
      default:     sel = RSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wts_adsr_env_channel.sv
// One ADSR envelope channel: pending key latch, rate counter, level and phase.
// Define WTS_ENV_SOFT_RETRIGGER_EN to keep the current level on a key_on with ar!=0.
module wts_adsr_env_channel
  import wts_env_pkg::*;
#(
  parameter int LEVEL_W = 9,
  parameter int RATE_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_i,
  input  logic               keyOn_i,
  input  logic               keyRelease_i,
  input  logic               keyOff_i,
  input  logic [RATE_W-1:0]  ar_i,
  input  logic [RATE_W-1:0]  dr_i,
  input  logic [RATE_W-1:0]  sr_i,
  input  logic [RATE_W-1:0]  rr_i,
  input  logic [LEVEL_W-2:0] sl_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic [STATE_W-1:0] state_o,
  output logic               noteEnd_o
);

  localparam logic [LEVEL_W:0] MAX_X = (LEVEL_W+1)'(1) << (LEVEL_W-1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [RATE_W-1:0]  counter_q, counter_d;
  logic               pendOn_q, pendOn_d;
  logic               pendRel_q, pendRel_d;
  logic               pendOff_q, pendOff_d;
  logic               noteEnd_q, noteEnd_d;

  envState_e          curState;
  logic [RATE_W-1:0]  rate;
  logic [LEVEL_W:0]   levelX;
  logic [LEVEL_W:0]   stepLevel;
  logic               evOn, evRel, evOff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ENV_IDLE;
      level_q   <= '0;
      counter_q <= '0;
      pendOn_q  <= 1'b0;
      pendRel_q <= 1'b0;
      pendOff_q <= 1'b0;
      noteEnd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      counter_q <= counter_d;
      pendOn_q  <= pendOn_d;
      pendRel_q <= pendRel_d;
      pendOff_q <= pendOff_d;
      noteEnd_q <= noteEnd_d;
    end
  end

  // Unused codes 5..7 fold onto IDLE before any decision is made.
  always_comb begin
    curState = (state_q > ENV_RELEASE) ? ENV_IDLE : envState_e'(state_q);
    rate     = '0;
    case (rateSel(curState))
      RSEL_AR: rate = ar_i;
      RSEL_DR: rate = dr_i;
      RSEL_SR: rate = sr_i;
      RSEL_RR: rate = rr_i;
      default: rate = '0;
    endcase
    levelX = {1'b0, level_q};
    if (curState == ENV_ATTACK) begin
      stepLevel = (levelX >= MAX_X) ? MAX_X : levelX + (LEVEL_W+1)'(1);
    end else begin
      stepLevel = (levelX == '0) ? '0 : levelX - (LEVEL_W+1)'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    counter_d = counter_q;
    noteEnd_d = 1'b0;
    evOn      = pendOn_q | keyOn_i;
    evRel     = pendRel_q | keyRelease_i;
    evOff     = pendOff_q | keyOff_i;
    pendOn_d  = evOn;
    pendRel_d = evRel;
    pendOff_d = evOff;
    if (active_i) begin
      pendOn_d  = 1'b0;
      pendRel_d = 1'b0;
      pendOff_d = 1'b0;
      if (evOff) begin
        state_d   = ENV_IDLE;
        level_d   = '0;
        counter_d = '0;
        noteEnd_d = (curState != ENV_IDLE);
      end else if (evOn) begin
        state_d   = ENV_ATTACK;
        counter_d = ar_i;
        if (ar_i == '0) begin
          level_d = MAX_X[LEVEL_W-1:0];
        end else begin
`ifdef WTS_ENV_SOFT_RETRIGGER_EN
          level_d = level_q;
`else
          level_d = '0;
`endif
        end
      end else if (evRel && curState != ENV_IDLE) begin
        state_d   = ENV_RELEASE;
        counter_d = rr_i;
      end else begin
        state_d = curState;
        if (counter_q == '0) begin
          counter_d = rate;
          if (rate != '0) level_d = stepLevel[LEVEL_W-1:0];
        end else begin
          counter_d = counter_q - RATE_W'(1);
        end
        // Phase changes look at the registered level; the counter takes the new phase's rate.
        case (curState)
          ENV_ATTACK: begin
            if (levelX == MAX_X) begin
              state_d   = ENV_DECAY;
              counter_d = dr_i;
            end
          end
          ENV_DECAY, ENV_SUSTAIN, ENV_RELEASE: begin
            if (level_q == '0) begin
              state_d   = ENV_IDLE;
              counter_d = '0;
              noteEnd_d = 1'b1;
            end else if (curState == ENV_DECAY && levelX <= {2'b00, sl_i}) begin
              state_d   = ENV_SUSTAIN;
              counter_d = sr_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign state_o   = state_q;
  assign noteEnd_o = noteEnd_q;

endmodule

// File: rtl/wts_multi_adsr_envelope.sv
// Multi-channel ADSR envelope generator: slices the packed register and output
// buses and instantiates one wts_adsr_env_channel per channel.
module wts_multi_adsr_envelope
  import wts_env_pkg::*;
#(
  parameter int CH_NUM  = 5,
  parameter int LEVEL_W = 9,
  parameter int RATE_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic [CH_NUM-1:0]            key_on,
  input  logic [CH_NUM-1:0]            key_release,
  input  logic [CH_NUM-1:0]            key_off,
  input  logic [CH_NUM*RATE_W-1:0]     reg_ar,
  input  logic [CH_NUM*RATE_W-1:0]     reg_dr,
  input  logic [CH_NUM*RATE_W-1:0]     reg_sr,
  input  logic [CH_NUM*RATE_W-1:0]     reg_rr,
  input  logic [CH_NUM*(LEVEL_W-1)-1:0] reg_sl,
  output logic [CH_NUM*LEVEL_W-1:0]    envelope,
  output logic [CH_NUM*STATE_W-1:0]    env_state,
  output logic [CH_NUM-1:0]            note_end
);

  for (genvar n = 0; n < CH_NUM; n++) begin : gCh
    wts_adsr_env_channel #(
      .LEVEL_W(LEVEL_W),
      .RATE_W (RATE_W)
    ) uChannel (
      .clk         (clk),
      .reset       (reset),
      .active_i    (active),
      .keyOn_i     (key_on[n]),
      .keyRelease_i(key_release[n]),
      .keyOff_i    (key_off[n]),
      .ar_i        (reg_ar[n*RATE_W +: RATE_W]),
      .dr_i        (reg_dr[n*RATE_W +: RATE_W]),
      .sr_i        (reg_sr[n*RATE_W +: RATE_W]),
      .rr_i        (reg_rr[n*RATE_W +: RATE_W]),
      .sl_i        (reg_sl[n*(LEVEL_W-1) +: (LEVEL_W-1)]),
      .level_o     (envelope[n*LEVEL_W +: LEVEL_W]),
      .state_o     (env_state[n*STATE_W +: STATE_W]),
      .noteEnd_o   (note_end[n])
    );
  end

endmodule

// File: tb/tb_wts_multi_adsr_envelope.sv
// Scoreboard bench for wts_multi_adsr_envelope: directed note scenarios followed by
// randomized key/rate traffic, checked against a per-channel behavioural envelope model.
module tb_wts_multi_adsr_envelope;

  localparam int CH   = 5;
  localparam int LW   = 9;
  localparam int RW   = 16;
  localparam int MAXL = 256;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  active;
  logic [CH-1:0]         keyOn, keyRel, keyOff;
  logic [CH*RW-1:0]      regAr, regDr, regSr, regRr;
  logic [CH*(LW-1)-1:0]  regSl;
  logic [CH*LW-1:0]      envelope;
  logic [CH*3-1:0]       envState;
  logic [CH-1:0]         noteEnd;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [CH*LW-1:0] env;
    logic [CH*3-1:0]  st;
    logic [CH-1:0]    ne;
  } expRec_t;

  expRec_t expQ[$];

  int mSt[CH], mLvl[CH], mCnt[CH];
  bit mPOn[CH], mPRel[CH], mPOff[CH], mNe[CH];

  wts_multi_adsr_envelope #(.CH_NUM(CH), .LEVEL_W(LW), .RATE_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .key_on     (keyOn),
    .key_release(keyRel),
    .key_off    (keyOff),
    .reg_ar     (regAr),
    .reg_dr     (regDr),
    .reg_sr     (regSr),
    .reg_rr     (regRr),
    .reg_sl     (regSl),
    .envelope   (envelope),
    .env_state  (envState),
    .note_end   (noteEnd)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int ch, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s ch%0d actual=%0d required=%0d at %0t", name, ch, act, req, $time);
    end
  endtask

  function automatic int rateAt(input logic [CH*RW-1:0] bus, input int c);
    return int'(bus[c*RW +: RW]);
  endfunction

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      mSt[c] = S_IDLE; mLvl[c] = 0; mCnt[c] = 0;
      mPOn[c] = 0; mPRel[c] = 0; mPOff[c] = 0; mNe[c] = 0;
    end
  endtask

  // Envelope rules per channel for one clk, using the inputs presented in that clk.
  task automatic modelStep(input bit act, input logic [CH-1:0] on, input logic [CH-1:0] rel,
                           input logic [CH-1:0] off);
    for (int c = 0; c < CH; c++) begin
      bit pOn, pRel, pOff;
      int r, oldLvl, ar, dr, sr, rr, sl;
      pOn  = mPOn[c] | on[c];
      pRel = mPRel[c] | rel[c];
      pOff = mPOff[c] | off[c];
      mNe[c] = 0;
      if (!act) begin
        mPOn[c] = pOn; mPRel[c] = pRel; mPOff[c] = pOff;
        continue;
      end
      mPOn[c] = 0; mPRel[c] = 0; mPOff[c] = 0;
      ar = rateAt(regAr, c); dr = rateAt(regDr, c);
      sr = rateAt(regSr, c); rr = rateAt(regRr, c);
      sl = int'(regSl[c*(LW-1) +: (LW-1)]);
      if (pOff) begin
        mNe[c] = (mSt[c] != S_IDLE);
        mSt[c] = S_IDLE; mLvl[c] = 0; mCnt[c] = 0;
      end else if (pOn) begin
        mSt[c] = S_ATTACK; mCnt[c] = ar;
        if (ar == 0) mLvl[c] = MAXL;
        else begin
`ifdef WTS_ENV_SOFT_RETRIGGER_EN
          mLvl[c] = mLvl[c];
`else
          mLvl[c] = 0;
`endif
        end
      end else if (pRel && mSt[c] != S_IDLE) begin
        mSt[c] = S_RELEASE; mCnt[c] = rr;
      end else begin
        case (mSt[c])
          S_ATTACK:  r = ar;
          S_DECAY:   r = dr;
          S_SUSTAIN: r = sr;
          S_RELEASE: r = rr;
          default:   r = 0;
        endcase
        oldLvl = mLvl[c];
        if (mCnt[c] == 0) begin
          mCnt[c] = r;
          if (r != 0) begin
            if (mSt[c] == S_ATTACK) mLvl[c] = (oldLvl + 1 > MAXL) ? MAXL : oldLvl + 1;
            else mLvl[c] = (oldLvl - 1 < 0) ? 0 : oldLvl - 1;
          end
        end else begin
          mCnt[c] = mCnt[c] - 1;
        end
        if (mSt[c] == S_ATTACK && oldLvl == MAXL) begin
          mSt[c] = S_DECAY; mCnt[c] = dr;
        end else if (mSt[c] >= S_DECAY && mSt[c] <= S_RELEASE && oldLvl == 0) begin
          mSt[c] = S_IDLE; mCnt[c] = 0; mNe[c] = 1;
        end else if (mSt[c] == S_DECAY && oldLvl <= sl) begin
          mSt[c] = S_SUSTAIN; mCnt[c] = sr;
        end
      end
    end
  endtask

  function automatic expRec_t packModel();
    expRec_t e;
    for (int c = 0; c < CH; c++) begin
      e.env[c*LW +: LW] = LW'(mLvl[c]);
      e.st[c*3 +: 3]    = 3'(mSt[c]);
      e.ne[c]           = mNe[c];
    end
    return e;
  endfunction

  // Called at a negedge: drive one clk of stimulus, queue the model's prediction.
  task automatic applyStimulus(input bit act, input logic [CH-1:0] on, input logic [CH-1:0] rel,
                               input logic [CH-1:0] off);
    active = act; keyOn = on; keyRel = rel; keyOff = off;
    modelStep(act, on, rel, off);
    expQ.push_back(packModel());
    @(negedge clk);
  endtask

  task automatic runActive(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, '0, '0, '0);
  endtask

  task automatic checkOutput(input expRec_t e);
    for (int c = 0; c < CH; c++) begin
      cmp("envelope",  c, int'(envelope[c*LW +: LW]), int'(e.env[c*LW +: LW]));
      cmp("env_state", c, int'(envState[c*3 +: 3]),   int'(e.st[c*3 +: 3]));
      cmp("note_end",  c, int'(noteEnd[c]),           int'(e.ne[c]));
    end
  endtask

  task automatic checkZero(input string tag);
    cmp({tag, "_envelope"},  -1, int'(envelope != '0), 0);
    cmp({tag, "_env_state"}, -1, int'(envState != '0), 0);
    cmp({tag, "_note_end"},  -1, int'(noteEnd != '0), 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic resetPulse();
    reset = 1'b1;
    active = 1'b0; keyOn = '0; keyRel = '0; keyOff = '0;
    modelReset();
    #1;
    checkZero("midreset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic setCh(input int c, input int ar, input int dr, input int sr, input int rr,
                       input int sl);
    regAr[c*RW +: RW] = RW'(ar);
    regDr[c*RW +: RW] = RW'(dr);
    regSr[c*RW +: RW] = RW'(sr);
    regRr[c*RW +: RW] = RW'(rr);
    regSl[c*(LW-1) +: (LW-1)] = (LW-1)'(sl);
  endtask

  // Monitor: every clk the DUT presents new registered outputs; compare against the queue head.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    logic [CH-1:0] on, rel, off;
    reset = 1'b1;
    active = 1'b0; keyOn = '0; keyRel = '0; keyOff = '0;
    regAr = '0; regDr = '0; regSr = '0; regRr = '0; regSl = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkZero("reset");
    reset = 1'b0;

    // Long notes: slow attack/decay into sustain, fast decay to a zero sustain level.
    setCh(0, 2, 1, 0, 3, 250);
    setCh(1, 0, 1, 0, 2, 100);
    setCh(2, 0, 2, 0, 1, 200);
    setCh(3, 1, 1, 1, 1, 50);
    setCh(4, 0, 1, 0, 1, 0);
    applyStimulus(1'b1, 5'b10011, '0, '0);
    runActive(820);

    // Retrigger ch1 from its sustain level with a slow attack.
    setCh(1, 5, 1, 0, 2, 100);
    applyStimulus(1'b1, 5'b00010, '0, '0);
    runActive(20);

    // Instant attack on ch2, then on+off together on ch3.
    applyStimulus(1'b1, 5'b00100, '0, '0);
    runActive(3);
    applyStimulus(1'b1, 5'b01000, '0, 5'b01000);
    applyStimulus(1'b0, '0, 5'b01000, '0);
    applyStimulus(1'b1, 5'b01000, '0, '0);

    // Release latched between active pulses, then run ch0 down to IDLE.
    applyStimulus(1'b0, '0, 5'b00001, '0);
    applyStimulus(1'b0, '0, '0, '0);
    runActive(1050);

    // Reset mid-attack on ch3 with pending events that must be discarded.
    setCh(3, 1, 1, 1, 1, 50);
    applyStimulus(1'b1, 5'b01000, '0, '0);
    runActive(154);
    applyStimulus(1'b0, 5'b00100, '0, 5'b01001);
    resetPulse();
    runActive(5);

    // Randomized traffic with periodic rate changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        for (int c = 0; c < CH; c++)
          setCh(c, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 255));
      end
      if (i % 1000 == 999) resetPulse();
      for (int c = 0; c < CH; c++) begin
        on[c]  = ($urandom_range(0, 29) == 0);
        rel[c] = ($urandom_range(0, 29) == 0);
        off[c] = ($urandom_range(0, 59) == 0);
      end
      applyStimulus($urandom_range(0, 2) != 0, on, rel, off);
    end

    active = 1'b0; keyOn = '0; keyRel = '0; keyOff = '0;
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
